// File: rtl/jtag_scan_host.sv
// jtag_scan_host
//   Host-side JTAG scan engine. Commands are taken on a valid/ready port. Each
//   one walks an IEEE 1149.1 TAP from Run-Test/Idle through an IR scan, a DR
//   scan or a TAP reset, and then back to Run-Test/Idle. The captured TDO bits
//   are returned with a one-cycle response pulse.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only while not scanning)
//   cmd_ir, cmd_reset     : scan type (IR/DR) or TAP reset (reset dominates)
//   cmd_len, cmd_data     : scan length 1..DATA_W, TDI bits LSB first
//   rsp_valid             : one-cycle completion pulse
//   rsp_err               : illegal length flag, qualified by rsp_valid
//   rsp_data              : captured TDO, bit i = i-th sample, upper bits 0
//   busy                  : inverse of cmd_ready
//   tck, tms, tdi, tdo    : JTAG pins (tdo already synchronous to clk)
module jtag_scan_host #(
    parameter int DATA_W  = 64,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ir,
    input  logic              cmd_reset,
    input  logic [6:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       LEN_MAX  = 8'(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic              mode_ir;
    logic              mode_rst;
    logic              bad;
    logic [6:0]        len;
    logic [7:0]        pulse_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              cur_data;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] cap;

    logic       accept;
    logic [7:0] pre;
    logic [7:0] nk;
    logic [7:0] end_data;
    logic [7:0] total;
    logic       n_data;
    logic       n_tms;
    logic       fall_ev;
    logic       rise_ev;
    logic       last_pulse;

    assign busy   = ~cmd_ready;
    assign accept = cmd_valid & cmd_ready;

    // Pulse k of a scan: preamble of 'pre' pulses, then the data pulses
    // pre+1..pre+len, then Update and Run-Test/Idle.
    assign pre        = mode_ir ? 8'd4 : 8'd3;
    assign nk         = pulse_cnt + 8'd1;
    assign end_data   = pre + {1'b0, len};
    assign total      = mode_rst ? 8'd6 : end_data + 8'd2;
    assign n_data     = !mode_rst && (nk > pre) && (nk <= end_data);
    assign n_tms      = mode_rst ? (nk <= 8'd5)
                                 : ((nk == 8'd1) || (mode_ir && nk == 8'd2) ||
                                    (nk == end_data) || (nk == end_data + 8'd1));
    assign last_pulse = (pulse_cnt == total);

    // pulse_cnt == 0 only in the first RUN cycle: that cycle loads pulse 1
    // exactly as a regular falling edge would, which gives the edge-1 setup.
    assign fall_ev = (state == RUN) && !bad &&
                     ((pulse_cnt == 8'd0) || (tck && div_cnt == DIV_LAST));
    assign rise_ev = (state == RUN) && !bad && (pulse_cnt != 8'd0) &&
                     !tck && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            tck       <= 1'b0;
            tms       <= 1'b0;
            tdi       <= 1'b0;
            mode_ir   <= 1'b0;
            mode_rst  <= 1'b0;
            bad       <= 1'b0;
            len       <= 7'd0;
            pulse_cnt <= 8'd0;
            div_cnt   <= '0;
            cur_data  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        state     <= RUN;
                        cmd_ready <= 1'b0;
                        mode_ir   <= cmd_ir;
                        mode_rst  <= cmd_reset;
                        len       <= cmd_len;
                        bad       <= !cmd_reset &&
                                     ((cmd_len == 7'd0) || ({1'b0, cmd_len} > LEN_MAX));
                        pulse_cnt <= 8'd0;
                        div_cnt   <= '0;
                        cur_data  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bad) begin
                        // Illegal length: respond without touching the TAP.
                        state     <= DONE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else if (fall_ev) begin
                        tck     <= 1'b0;
                        div_cnt <= '0;
                        if (last_pulse) begin
                            state     <= DONE;
                            cmd_ready <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            // Samples were shifted in from the top; align bit 0.
                            rsp_data  <= mode_rst ? '0 : (cap >> (LEN_MAX - {1'b0, len}));
                            tms       <= 1'b0;
                            tdi       <= 1'b0;
                            cur_data  <= 1'b0;
                        end else begin
                            pulse_cnt <= nk;
                            tms       <= n_tms;
                            tdi       <= n_data & sreg[0];
                            cur_data  <= n_data;
                        end
                    end else if (rise_ev) begin
                        tck     <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // TDI source and TDO capture shift registers (no reset needed: both are
    // loaded on acceptance before use).
    always_ff @(posedge clk) begin
        if (accept) begin
            sreg <= cmd_data;
            cap  <= '0;
        end else begin
            if (fall_ev && !last_pulse && n_data)
                sreg <= sreg >> 1;
            if (rise_ev && cur_data)
                cap <= {tdo, cap[DATA_W-1:1]};
        end
    end

endmodule

// File: tb/tb_jtag_scan_host.sv
// tb_jtag_scan_host
//   Directed bench for jtag_scan_host (DATA_W=64, CLK_DIV=2) with a behavioural
//   16-state TAP target holding a variable-length DR and a 10-bit IR.
module tb_jtag_scan_host;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_ir = 1'b0;
    logic        cmd_reset = 1'b0;
    logic [6:0]  cmd_len = 7'd0;
    logic [63:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo = 1'b0;

    jtag_scan_host #(.DATA_W(64), .CLK_DIV(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_reset(cmd_reset), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // ---------------- TAP target model ----------------
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDDR,
                              SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPDIR} tap_t;

    tap_t        tap = RTI;
    logic [63:0] dr = '0;
    logic [63:0] dsr = '0;
    int          dr_len = 8;
    logic [9:0]  ir = '0;
    logic [9:0]  isr = '0;
    logic [63:0] tms_hist = '0;
    logic [63:0] tdi_hist = '0;
    int          tck_cnt = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDDR : PDR;
            PDR:   return m ? EX2DR : PDR;
            EX2DR: return m ? UPDDR : SHDR;
            UPDDR: return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPDIR : PIR;
            PIR:   return m ? EX2IR : PIR;
            EX2IR: return m ? UPDIR : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        tck_cnt  = tck_cnt + 1;
        tms_hist = {tms_hist[62:0], tms};
        tdi_hist = {tdi_hist[62:0], tdi};
        case (tap)
            CAPDR: dsr = dr;
            SHDR:  dsr = (dsr >> 1) | (64'(tdi) << (dr_len - 1));
            UPDDR: dr  = dsr;
            CAPIR: isr = 10'h001;
            SHIR:  isr = {tdi, isr[9:1]};
            UPDIR: ir  = isr;
            default: ;
        endcase
        tap = tap_next(tap, tms);
    end

    always @(negedge tck) begin
        if (tap == SHDR)      tdo = dsr[0];
        else if (tap == SHIR) tdo = isr[0];
        else                  tdo = 1'b0;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    time         t0;
    int          r_lat;
    logic [63:0] r_data;
    logic        r_err;
    logic        r_tck;
    logic        r_tms;

    task automatic start_cmd(input logic ir_s, input logic rst_s, input logic [6:0] len_s,
                             input logic [63:0] data_s);
        int n;
        @(negedge clk);
        tms_hist  = '0;
        tdi_hist  = '0;
        tck_cnt   = 0;
        cmd_ir    = ir_s;
        cmd_reset = rst_s;
        cmd_len   = len_s;
        cmd_data  = data_s;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        t0 = $time;
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) chk("rsp_timeout", 64'(n), 64'd0);
        r_lat  = int'(($time - t0 - 1) / 10);
        r_data = rsp_data;
        r_err  = rsp_err;
        r_tck  = tck;
        r_tms  = tms;
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        chk("rsp_data_hold", rsp_data, r_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        // Reset asserted between clock edges
        #2 reset = 1'b1;
        #1;
        chk("reset_pins", {61'd0, tck, tms, tdi}, 64'd0);
        chk("reset_hs", {60'd0, cmd_ready, busy, rsp_valid, rsp_err}, 64'b1000);
        chk("reset_rsp_data", rsp_data, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Short DR scan, target DR preloaded with 0x3C
        dr_len = 8;
        dr     = 64'h3C;
        start_cmd(1'b0, 1'b0, 7'd8, 64'hA5);
        wait_rsp();
        chk("dr8_lat", 64'(r_lat), 64'd53);
        chk("dr8_data", r_data, 64'h3C);
        chk("dr8_err", 64'(r_err), 64'd0);
        chk("dr8_tms", tms_hist, 64'h1006);
        chk("dr8_tdi", tdi_hist, 64'h0294);
        chk("dr8_pulses", 64'(tck_cnt), 64'd13);
        chk("dr8_target", dr, 64'hA5);
        chk("dr8_tap", 64'(tap), 64'(RTI));
        chk("dr8_end_pins", {62'd0, r_tck, r_tms}, 64'd0);

        // IR scan, 10 bits
        start_cmd(1'b1, 1'b0, 7'd10, 64'h2AA);
        wait_rsp();
        chk("ir_lat", 64'(r_lat), 64'd65);
        chk("ir_tms", tms_hist, 64'hC006);
        chk("ir_pulses", 64'(tck_cnt), 64'd16);
        chk("ir_target", 64'(ir), 64'h2AA);
        chk("ir_tap", 64'(tap), 64'(RTI));
        chk("ir_data", r_data, 64'h001);

        // TAP reset from Pause-DR; length 0 must be ignored
        tap = PDR;
        start_cmd(1'b0, 1'b1, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_rsp();
        chk("trst_lat", 64'(r_lat), 64'd25);
        chk("trst_tms", tms_hist, 64'h3E);
        chk("trst_pulses", 64'(tck_cnt), 64'd6);
        chk("trst_tap", 64'(tap), 64'(RTI));
        chk("trst_data", r_data, 64'd0);
        chk("trst_err", 64'(r_err), 64'd0);

        // Illegal lengths
        start_cmd(1'b0, 1'b0, 7'd0, 64'h1);
        wait_rsp();
        chk("len0_lat", 64'(r_lat), 64'd1);
        chk("len0_err", 64'(r_err), 64'd1);
        chk("len0_pulses", 64'(tck_cnt), 64'd0);
        start_cmd(1'b1, 1'b0, 7'd65, 64'h1);
        wait_rsp();
        chk("len65_lat", 64'(r_lat), 64'd1);
        chk("len65_err", 64'(r_err), 64'd1);
        chk("len65_pulses", 64'(tck_cnt), 64'd0);

        // Full-width DR through a 1-bit (bypass-like) DR: tdo = tdi one pulse late
        dr_len = 1;
        dr     = 64'd0;
        start_cmd(1'b0, 1'b0, 7'd64, 64'hDEAD_BEEF_0123_4567);
        repeat (5) @(negedge clk);
        chk("busy_flag", {62'd0, busy, cmd_ready}, 64'b10);
        cmd_ir    = 1'b1;
        cmd_len   = 7'd3;
        cmd_data  = 64'h5;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp();
        chk("dr64_lat", 64'(r_lat), 64'd277);
        chk("dr64_data", r_data, 64'hBD5B_7DDE_0246_8ACE);
        chk("dr64_err", 64'(r_err), 64'd0);
        chk("dr64_target", dr, 64'd1);
        chk("dr64_tap", 64'(tap), 64'(RTI));
        repeat (20) @(negedge clk);
        chk("ignored_cmd_pulses", 64'(tck_cnt), 64'd69);

        // Abort a scan with reset after pulse 4
        dr_len = 8;
        start_cmd(1'b0, 1'b0, 7'd8, 64'hFF);
        begin
            int n;
            n = 0;
            while (tck_cnt < 4 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("abort_pulse4_tck", 64'(tck), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_pins", {61'd0, tck, tms, tdi}, 64'd0);
        chk("abort_hs", {61'd0, cmd_ready, busy, rsp_valid}, 64'b100);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);

        start_cmd(1'b0, 1'b1, 7'd8, 64'h0);
        wait_rsp();
        chk("recover_trst_lat", 64'(r_lat), 64'd25);
        chk("recover_trst_tap", 64'(tap), 64'(RTI));
        dr = 64'h5A;
        start_cmd(1'b0, 1'b0, 7'd8, 64'h81);
        wait_rsp();
        chk("recover_dr_lat", 64'(r_lat), 64'd53);
        chk("recover_dr_data", r_data, 64'h5A);
        chk("recover_dr_target", dr, 64'h81);
        chk("recover_dr_tap", 64'(tap), 64'(RTI));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
